cnt_seq_ctrl: RTL
=================

CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 The parameter list SHALL be: CNT_W, default 4, counter width in bits (fixed at 4 for this block).
REQ-002 Port clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  request a run, sampled only in IDLE.
REQ-005 Port up_down  input  1  run direction latched at start: 1 = up, 0 = down.
REQ-006 Port target  input  4  end value latched at start.
REQ-007 Port hold  input  1  freeze counting for the current cycle while in RUN.
REQ-008 Port stop  input  1  abort the run while in RUN.
REQ-009 Port count  output  4  current counter value.
REQ-010 Port busy  output  1  high while in RUN.
REQ-011 Port done  output  1  one-cycle pulse on run completion.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 at an edge SHALL latch up_down and target, and move to RUN; count SHALL NOT change on that edge.
REQ-014 In RUN, each edge with stop=0 and hold=0 SHALL step count by +1 (up) or -1 (down), modulo 16 (15+1 gives 0, 0-1 gives 15).
REQ-015 In RUN, an edge with hold=1 and stop=0 SHALL leave count and state unchanged.
REQ-016 In RUN, an edge with stop=1 SHALL go to IDLE with count unchanged and no done pulse; stop SHALL override hold.
REQ-017 When a step makes count equal the latched target, the same edge SHALL move the FSM to DONE.
REQ-018 If target equals count at start, the run SHALL take 16 steps (full wrap) before completing.
REQ-019 If stop=1 on the edge that would reach target, stop SHALL win: no step and no done.
REQ-020 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-021 start SHALL be ignored in RUN and DONE, and changes to up_down or target SHALL be ignored outside the IDLE accept edge.
REQ-022 busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE; both SHALL be decoded from registered state.
REQ-023 count SHALL hold its value in IDLE and DONE, and a new run SHALL start from the held value.
REQ-024 Latency SHALL be N+1 edges from the start edge to the DONE state, where N = steps needed, and done SHALL be visible in the cycle after the final step.

Reset
REQ-025 While reset=1 at an edge, the next state SHALL be IDLE, with count=0, busy=0, done=0, and the latched direction=1 and target=0.
REQ-026 reset SHALL take priority over start, stop, hold and any in-progress run.
REQ-027 After reset is released, the first edge with start=1 SHALL be accepted.

Structure
REQ-028 A shared package cnt_seq_pkg SHALL hold the CNT_W constant and the state enum typedef (IDLE, RUN, DONE).
REQ-029 The datapath SHALL be one sub-module, updown_cnt4 (ports: clk, reset, en, up, count), enabled by the FSM only on valid RUN steps.
REQ-030 The controller SHALL contain no other storage than the state, the latched direction and the latched target.

Verification
REQ-031 Reset, then start with up_down=1 and target=3 -> count goes 1,2,3 on edges 1-3, done pulses for one cycle, then IDLE with count=3.
REQ-032 From count=1, start with up_down=0 and target=14 -> count goes 0,15,14, then done, with wrap-around confirmed.
REQ-033 From count=5, start with up_down=1 and target=5 -> 16 steps, then done, with count=5.
REQ-034 Start toward target=9 from 0, hold=1 for 3 cycles mid-run -> count frozen during the hold, and done comes 3 cycles later than without hold.
REQ-035 Assert stop together with hold, then separately on the final step edge -> immediate IDLE, count unchanged, no done pulse in either case.
REQ-036 Assert reset mid-run at count=7 -> next cycle count=0, busy=0; start asserted during RUN has no effect.

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// Shared constants and state encoding for the run/step counter controller.
package cnt_seq_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/updown_cnt4.sv
// Wrapping up/down counter; advances by one on enabled edges only.
module updown_cnt4
   import cnt_seq_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         count <= up ? count + CNT_W'(1) : count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Run controller: accepts a start in IDLE, steps the counter toward a latched
// target in RUN, and pulses done for one cycle in DONE.
module cnt_seq_ctrl #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             up_down,
   input  logic [CNT_W-1:0] target,
   input  logic             hold,
   input  logic             stop,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done
);
   import cnt_seq_pkg::*;

   state_t           state_q, state_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] tgt_q, tgt_d;
   logic             step_c;
   logic [CNT_W-1:0] next_cnt_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         dir_q   <= 1'b1;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         tgt_q   <= tgt_d;
      end
   end

   // Stop beats hold, and both beat reaching the target.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      tgt_d      = tgt_q;
      step_c     = 1'b0;
      next_cnt_c = dir_q ? count + CNT_W'(1) : count - CNT_W'(1);
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               dir_d   = up_down;
               tgt_d   = target;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (!hold) begin
               step_c = 1'b1;
               if (next_cnt_c == tgt_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   updown_cnt4 u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (step_c),
      .up    (dir_q),
      .count (count)
   );

endmodule
